mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle RV32I core's load/store and fetch traffic. It accepts one request at a time over a valid/ready handshake and waits a programmable number of cycles.
- It then returns a single-cycle response carrying read data or a write acknowledgement.
- It performs byte-lane selection, little-endian packing and load sign/zero extension from funct3, so the datapath receives architecturally final load values.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words of backing storage; word index = addr[31:2].
- LATENCY, 2: cycles from the request-acceptance cycle to the response cycle; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load or fetch.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; sb uses bits 7:0, sh uses bits 15:0.
- req_size  input  3  funct3 of the access (fetch uses 3'b010).
- rsp_valid  output  1  response pulse, exactly one cycle.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  qualified by rsp_valid; access rejected.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, latency counter = 0.
  - Storage contents are not cleared.
  - Reset during WAIT or RESP aborts the transaction; a pending store is never committed.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready = 1. When req_valid is 1, latch addr/wdata/size/write and set counter = LATENCY-1. Next state is RESP if LATENCY = 1, else WAIT.
  - WAIT: req_ready = 0. Decrement the counter; move to RESP on the cycle the counter reaches 1.
  - RESP: req_ready = 0, rsp_valid = 1. Next state is IDLE unconditionally.
- Timing:
  - rsp_valid is high exactly LATENCY cycles after the acceptance cycle.
  - Minimum request spacing is LATENCY+1 cycles.
  - req_* inputs are ignored outside IDLE; latched values are used.
- Response outputs are driven combinationally from latched request state plus storage in RESP, and are 0 in all other states.
- Store commit:
  - Storage is written at the rising edge ending the RESP cycle, only when rsp_err = 0.
  - Only the addressed byte lanes change.
  - A read immediately following a write to the same word returns the new data.
- Byte lanes (little-endian; lane n = bits 8n+7:8n):
  - Byte access: lane addr[1:0].
  - Half access: lanes {addr[1],0} and {addr[1],1}.
  - Word access: all four lanes.
- Load extension by req_size:
  - 000 lb: sign-extend byte.
  - 001 lh: sign-extend half.
  - 010 lw: full word.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half.
- Store sizes: 000 sb, 001 sh, 010 sw.
- rsp_err = 1 when any of the following holds:
  - Illegal size: 011, 110 or 111 for any access; 100 or 101 on a store.
  - Misaligned half: addr[0] = 1.
  - Misaligned word: addr[1:0] != 0.
  - Out of range: addr[31:2] >= DEPTH_WORDS.
- On error: rsp_rdata = 0, no storage change, FSM timing identical to a good access.

Test Plan:
- LATENCY=2, reset, then sw addr 0x10 data 0xDEADBEEF -> req_ready low for 2 cycles, rsp_valid one cycle at acceptance+2, rsp_err=0; then lw 0x10 -> rsp_rdata 0xDEADBEEF.
- After the above, sb 0x11 data 0x000000A5; lw 0x10 -> 0xDEADA5EF; lb 0x11 -> 0xFFFFFFA5; lbu 0x11 -> 0x000000A5.
- sh 0x12 data 0x00008001, then lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001; lw 0x10 -> 0x8001A5EF.
- Errors:
  - lw 0x13 -> rsp_err=1, rdata 0.
  - sh 0x11 -> rsp_err=1, word at 0x10 unchanged.
  - lw 0x1000 with DEPTH_WORDS=1024 -> rsp_err=1.
  - size 3'b011 -> rsp_err=1.
- Back-to-back with req_valid held high: acceptances spaced exactly LATENCY+1 cycles. Rerun with LATENCY=1: response the cycle after acceptance, spacing 2.
- Issue sw 0x20 data 0x12345678 after a prior sw 0x20 data 0x0; assert rst low during WAIT -> outputs at reset values immediately; after release, lw 0x20 -> 0x00000000 (store aborted).

Source files
------------

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable response latency,
// little-endian byte-lane stores and funct3-driven load extension.
module mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_size,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  size_q, size_d;
   logic        write_q, write_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic [AW-1:0] idx;
   logic [31:0]   word;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_val;
   logic          size_bad;
   logic          misaligned;
   logic          out_of_range;
   logic          err;
   logic [3:0]    wmask;
   logic [31:0]   wbytes;
   logic          commit;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         write_q <= write_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      write_d = write_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               size_d  = req_size;
               write_d = req_write;
               cnt_d   = 4'(LATENCY - 1);
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            // The counter holds the remaining WAIT cycles including this one.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- access checks
   always_comb begin
      size_bad   = 1'b0;
      misaligned = 1'b0;
      unique case (size_q)
         3'b000:  ;
         3'b001:  misaligned = addr_q[0];
         3'b010:  misaligned = |addr_q[1:0];
         3'b100:  size_bad = write_q;
         3'b101: begin
            size_bad   = write_q;
            misaligned = addr_q[0];
         end
         default: size_bad = 1'b1;
      endcase
   end

   assign out_of_range = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
   assign err          = size_bad | misaligned | out_of_range;

   // ---------------------------------------------------------------- load path
   assign idx      = addr_q[AW+1:2];
   assign word     = mem_q[idx];
   assign byte_sel = word[{addr_q[1:0], 3'b000} +: 8];
   assign half_sel = addr_q[1] ? word[31:16] : word[15:0];

   always_comb begin
      load_val = '0;
      unique case (size_q)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b010:  load_val = word;
         3'b100:  load_val = {24'h000000, byte_sel};
         3'b101:  load_val = {16'h0000, half_sel};
         default: load_val = '0;
      endcase
   end

   // ---------------------------------------------------------------- store path
   always_comb begin
      wmask  = '0;
      wbytes = '0;
      unique case (size_q[1:0])
         2'b00: begin
            wmask  = 4'b0001 << addr_q[1:0];
            wbytes = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            wmask  = addr_q[1] ? 4'b1100 : 4'b0011;
            wbytes = {2{wdata_q[15:0]}};
         end
         2'b10: begin
            wmask  = 4'b1111;
            wbytes = wdata_q;
         end
         default: begin
            wmask  = '0;
            wbytes = '0;
         end
      endcase
   end

   // Commit lands on the edge that closes RESP; reset forces IDLE so an
   // aborted store can never reach this point.
   assign commit = (state_q == RESP) && write_q && !err;

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (wmask[i]) mem_q[idx][8*i +: 8] <= wbytes[8*i +: 8];
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_err   = rsp_valid && err;
   assign rsp_rdata = (rsp_valid && !err && !write_q) ? load_val : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 1) share request fields but
// have separate valids; a monitor checks every response against the queue.
module tb_mem_responder;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_size;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata [2];
   logic [1:0]  rsp_err;

   typedef struct {
      int          g;
      int          cyc;
      logic        err;
      logic [31:0] dat;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          acc_cnt = 0;
   int          last_acc = 0;
   logic        exp_err_v;
   logic [31:0] exp_data_v;

   for (genvar g = 0; g < 2; g++) begin : gi
      mem_responder #(
         .DEPTH_WORDS (1024),
         .LATENCY     ((g == 0) ? 2 : 1)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_write (req_write),
         .req_addr  (req_addr),
         .req_wdata (req_wdata),
         .req_size  (req_size),
         .rsp_valid (rsp_valid[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat_of(input int g);
      return (g == 0) ? 2 : 1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Acceptance tracker: records the handshake cycle and queues the expectation.
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (rst && req_valid[g] && req_ready[g]) begin
            sbq.push_back('{g: g, cyc: cyc + lat_of(g), err: exp_err_v, dat: exp_data_v});
            acc_cnt++;
            last_acc = cyc;
         end
      end
      cyc++;
   end

   // Monitor: every response pulse must match the head of the queue.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (rsp_valid[g]) begin
            if (sbq.size() == 0) begin
               check("unexpected_rsp", 32'(g), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("rsp_inst", 32'(g), 32'(e.g));
               check("rsp_cycle", 32'(cyc), 32'(e.cyc));
               check("rsp_err", {31'b0, rsp_err[g]}, {31'b0, e.err});
               check("rsp_rdata", rsp_rdata[g], e.dat);
            end
         end
      end
   end

   task automatic issue(input int g, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] sz,
                        input logic e_err, input logic [31:0] e_dat,
                        input bit hold, input bit chk_sp);
      int start;
      int prev;
      bit got;
      req_write  = wr;
      req_addr   = a;
      req_wdata  = wd;
      req_size   = sz;
      exp_err_v  = e_err;
      exp_data_v = e_dat;
      req_valid[g] = 1'b1;
      start = acc_cnt;
      prev  = last_acc;
      got   = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (acc_cnt != start) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("accept_timeout", 32'(acc_cnt), 32'(start + 1));
      else if (chk_sp) check("accept_spacing", 32'(last_acc - prev), 32'(lat_of(g) + 1));
      if (!hold) req_valid[g] = 1'b0;
   endtask

   task automatic check_idle_outputs(input int g);
      check("rst_ready", {31'b0, req_ready[g]}, 32'd1);
      check("rst_valid", {31'b0, rsp_valid[g]}, 32'd0);
      check("rst_err", {31'b0, rsp_err[g]}, 32'd0);
      check("rst_rdata", rsp_rdata[g], 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d expected=<200000", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst        = 1'b0;
      req_valid  = '0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_size   = 3'b010;
      exp_err_v  = 1'b0;
      exp_data_v = '0;
      repeat (3) @(negedge clk);
      check_idle_outputs(0);
      check_idle_outputs(1);
      #2 rst = 1'b1;
      @(negedge clk);

      // sw then observe ready low for WAIT and RESP
      issue(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 32'h0, 0, 0);
      check("ready_wait", {31'b0, req_ready[0]}, 32'd0);
      @(negedge clk);
      check("ready_resp", {31'b0, req_ready[0]}, 32'd0);
      @(negedge clk);
      check("ready_idle", {31'b0, req_ready[0]}, 32'd1);
      issue(0, 0, 32'h10, 32'h0, 3'b010, 0, 32'hDEADBEEF, 0, 0);

      // byte store and loads
      issue(0, 1, 32'h11, 32'h000000A5, 3'b000, 0, 32'h0, 0, 0);
      issue(0, 0, 32'h10, 32'h0, 3'b010, 0, 32'hDEADA5EF, 0, 0);
      issue(0, 0, 32'h11, 32'h0, 3'b000, 0, 32'hFFFFFFA5, 0, 0);
      issue(0, 0, 32'h11, 32'h0, 3'b100, 0, 32'h000000A5, 0, 0);

      // half store and loads
      issue(0, 1, 32'h12, 32'h00008001, 3'b001, 0, 32'h0, 0, 0);
      issue(0, 0, 32'h12, 32'h0, 3'b001, 0, 32'hFFFF8001, 0, 0);
      issue(0, 0, 32'h12, 32'h0, 3'b101, 0, 32'h00008001, 0, 0);
      issue(0, 0, 32'h10, 32'h0, 3'b010, 0, 32'h8001A5EF, 0, 0);

      // error cases
      issue(0, 0, 32'h13, 32'h0, 3'b010, 1, 32'h0, 0, 0);
      issue(0, 1, 32'h11, 32'h0000FFFF, 3'b001, 1, 32'h0, 0, 0);
      issue(0, 0, 32'h10, 32'h0, 3'b010, 0, 32'h8001A5EF, 0, 0);
      issue(0, 0, 32'h1000, 32'h0, 3'b010, 1, 32'h0, 0, 0);
      issue(0, 0, 32'h10, 32'h0, 3'b011, 1, 32'h0, 0, 0);
      issue(0, 1, 32'h10, 32'h0, 3'b100, 1, 32'h0, 0, 0);
      issue(0, 0, 32'h10, 32'h0, 3'b010, 0, 32'h8001A5EF, 0, 0);

      // last in-range word
      issue(0, 1, 32'hFFC, 32'hCAFEF00D, 3'b010, 0, 32'h0, 0, 0);
      issue(0, 0, 32'hFFC, 32'h0, 3'b010, 0, 32'hCAFEF00D, 0, 0);

      // back-to-back, LATENCY 2
      issue(0, 0, 32'h10, 32'h0, 3'b010, 0, 32'h8001A5EF, 1, 0);
      issue(0, 0, 32'h12, 32'h0, 3'b101, 0, 32'h00008001, 1, 1);
      issue(0, 0, 32'h10, 32'h0, 3'b000, 0, 32'hFFFFFFEF, 0, 1);
      repeat (3) @(negedge clk);

      // LATENCY 1 instance
      issue(1, 1, 32'h40, 32'h11223344, 3'b010, 0, 32'h0, 1, 0);
      issue(1, 0, 32'h40, 32'h0, 3'b010, 0, 32'h11223344, 1, 1);
      issue(1, 0, 32'h42, 32'h0, 3'b001, 0, 32'h00001122, 1, 1);
      issue(1, 0, 32'h43, 32'h0, 3'b000, 0, 32'h00000011, 1, 1);
      issue(1, 0, 32'h41, 32'h0, 3'b010, 1, 32'h0, 0, 1);
      repeat (3) @(negedge clk);

      // reset during WAIT aborts the pending store
      issue(0, 1, 32'h20, 32'h0, 3'b010, 0, 32'h0, 0, 0);
      issue(0, 1, 32'h20, 32'h12345678, 3'b010, 0, 32'h0, 0, 0);
      check("abort_in_wait", {31'b0, req_ready[0]}, 32'd0);
      #1 rst = 1'b0;
      #1 check_idle_outputs(0);
      sbq.delete();
      @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      issue(0, 0, 32'h20, 32'h0, 3'b010, 0, 32'h00000000, 0, 0);

      repeat (5) @(negedge clk);
      check("queue_drained", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
